// File: rtl/fp32_sig_align_add_norm_if.sv
// Operand/result bus of the FP32 significand align-add-normalise stage.
//   in_valid, sig_non_shift, sig_shift, shift_amt, exp_in : operands, producer -> stage
//   out_valid, norm_sig, norm_exp, cout, overflow, zero   : registered result, stage -> consumer
// master = operand producer / result consumer; slave = the datapath stage.
interface fp32_sig_align_add_norm_if;
    logic        in_valid;
    logic [23:0] sig_non_shift;
    logic [23:0] sig_shift;
    logic [7:0]  shift_amt;
    logic [7:0]  exp_in;
    logic        out_valid;
    logic [23:0] norm_sig;
    logic [7:0]  norm_exp;
    logic        cout;
    logic        overflow;
    logic        zero;

    modport master (
        output in_valid, sig_non_shift, sig_shift, shift_amt, exp_in,
        input  out_valid, norm_sig, norm_exp, cout, overflow, zero
    );

    modport slave (
        input  in_valid, sig_non_shift, sig_shift, shift_amt, exp_in,
        output out_valid, norm_sig, norm_exp, cout, overflow, zero
    );
endinterface

// File: rtl/fp32_sig_align_add_norm.sv
// Registered significand datapath of the FP32 adder: right-align the
// smaller-exponent significand, carry-select add, normalise, adjust exponent.
// Ports:
//   clk   : clock, all state on rising edge
//   rst_n : synchronous active-low reset, clears all outputs
//   bus   : slave side of fp32_sig_align_add_norm_if (operands in, result out)
// Latency 1; data outputs hold while in_valid is low.
module fp32_sig_align_add_norm (
    input  logic                          clk,
    input  logic                          rst_n,
    fp32_sig_align_add_norm_if.slave      bus
);
    localparam int unsigned SIG_W  = 24;
    localparam int unsigned HALF_W = 12;
    localparam int unsigned EXP_W  = 8;
    localparam int unsigned LZ_W   = 5;

    logic [SIG_W-1:0]  shifted_c;
    logic [HALF_W:0]   lo_c;
    logic [HALF_W:0]   hi0_c;
    logic [HALF_W:0]   hi1_c;
    logic              carry_c;
    logic [SIG_W-1:0]  sum_c;
    logic [LZ_W-1:0]   lz_c;
    logic              found_c;
    logic [EXP_W-1:0]  lim_c;
    logic [LZ_W-1:0]   s_c;

    logic              valid_d, valid_q;
    logic [SIG_W-1:0]  sig_d, sig_q;
    logic [EXP_W-1:0]  exp_d, exp_q;
    logic              cout_d, cout_q;
    logic              ovf_d, ovf_q;
    logic              zero_d, zero_q;

    // Logical right alignment; any distance >= 24 empties the significand.
    always_comb begin
        shifted_c = '0;
        if (bus.shift_amt < EXP_W'(SIG_W))
            shifted_c = bus.sig_shift >> bus.shift_amt[LZ_W-1:0];
    end

    // Carry-select add: upper half precomputed for both carry-ins.
    always_comb begin
        lo_c    = {1'b0, bus.sig_non_shift[HALF_W-1:0]} + {1'b0, shifted_c[HALF_W-1:0]};
        hi0_c   = {1'b0, bus.sig_non_shift[SIG_W-1:HALF_W]} + {1'b0, shifted_c[SIG_W-1:HALF_W]};
        hi1_c   = hi0_c + (HALF_W+1)'(1);
        carry_c = lo_c[HALF_W] ? hi1_c[HALF_W] : hi0_c[HALF_W];
        sum_c   = {(lo_c[HALF_W] ? hi1_c[HALF_W-1:0] : hi0_c[HALF_W-1:0]), lo_c[HALF_W-1:0]};
    end

    // Leading-zero count of the sum, scanning from the MSB.
    always_comb begin
        lz_c    = '0;
        found_c = 1'b0;
        for (int i = SIG_W - 1; i >= 0; i--) begin
            if (!found_c) begin
                if (sum_c[i]) found_c = 1'b1;
                else          lz_c    = lz_c + LZ_W'(1);
            end
        end
    end

    // Left-shift limited so the exponent never drops below 1 (0 stays 0).
    always_comb begin
        lim_c = bus.exp_in - EXP_W'(1);
        s_c   = '0;
        if (bus.exp_in != '0)
            s_c = (EXP_W'(lz_c) < lim_c) ? lz_c : lim_c[LZ_W-1:0];
    end

    // Normalisation priority and output next-state.
    always_comb begin
        valid_d = 1'b0;
        sig_d   = sig_q;
        exp_d   = exp_q;
        cout_d  = cout_q;
        ovf_d   = ovf_q;
        zero_d  = zero_q;
        if (bus.in_valid) begin
            valid_d = 1'b1;
            cout_d  = carry_c;
            ovf_d   = 1'b0;
            zero_d  = 1'b0;
            if (carry_c && (bus.exp_in >= EXP_W'(254))) begin
                sig_d = 24'h800000;
                exp_d = '1;
                ovf_d = 1'b1;
            end else if (carry_c) begin
                sig_d = {1'b1, sum_c[SIG_W-1:1]};
                exp_d = bus.exp_in + EXP_W'(1);
            end else if (sum_c == '0) begin
                sig_d  = '0;
                exp_d  = '0;
                zero_d = 1'b1;
            end else begin
                sig_d = sum_c << s_c;
                exp_d = bus.exp_in - EXP_W'(s_c);
                // Still not normalised: encode as denormal.
                if (!sig_d[SIG_W-1]) exp_d = '0;
            end
        end
    end

    // Output register stage with synchronous reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            sig_q   <= '0;
            exp_q   <= '0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
            zero_q  <= 1'b0;
        end else begin
            valid_q <= valid_d;
            sig_q   <= sig_d;
            exp_q   <= exp_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
            zero_q  <= zero_d;
        end
    end

    assign bus.out_valid = valid_q;
    assign bus.norm_sig  = sig_q;
    assign bus.norm_exp  = exp_q;
    assign bus.cout      = cout_q;
    assign bus.overflow  = ovf_q;
    assign bus.zero      = zero_q;
endmodule

// File: tb/tb_fp32_sig_align_add_norm.sv
// Self-checking bench for fp32_sig_align_add_norm: directed spec vectors,
// random vectors against a behavioural model, handshake/reset/hold checks.
module tb_fp32_sig_align_add_norm;
    typedef struct packed {
        logic [23:0] sig;
        logic [7:0]  exp;
        logic        cout;
        logic        ovf;
        logic        zero;
    } res_t;

    logic clk;
    logic rst_n;
    int   n_vec;
    int   n_err;
    res_t sb_q[$];
    res_t last_exp;

    fp32_sig_align_add_norm_if bus ();

    fp32_sig_align_add_norm dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Behavioural model: plain add, normalise by shifting one bit at a time.
    function automatic res_t model(input logic [23:0] a, input logic [23:0] b,
                                   input logic [7:0] amt, input logic [7:0] e);
        res_t        r;
        logic [23:0] sh;
        logic [24:0] t;
        logic [23:0] sg;
        int          ee;
        sh = (amt < 8'd24) ? (b >> amt) : 24'd0;
        t  = {1'b0, a} + {1'b0, sh};
        r  = '0;
        r.cout = t[24];
        if (t[24]) begin
            if (e >= 8'd254) begin
                r.sig = 24'h800000; r.exp = 8'hFF; r.ovf = 1'b1;
            end else begin
                r.sig = t[24:1]; r.exp = e + 8'd1;
            end
        end else if (t[23:0] == 24'd0) begin
            r.zero = 1'b1;
        end else begin
            sg = t[23:0];
            ee = int'(e);
            while (!sg[23] && ee > 1) begin
                sg = sg << 1;
                ee--;
            end
            if (!sg[23]) ee = 0;
            r.sig = sg;
            r.exp = 8'(ee);
        end
        return r;
    endfunction

    // Drive one cycle of stimulus at the falling edge; queue expected result.
    task automatic apply(input logic v, input logic [23:0] a, input logic [23:0] b,
                         input logic [7:0] amt, input logic [7:0] e,
                         input logic use_exp, input res_t ex);
        res_t r;
        @(negedge clk);
        bus.in_valid      = v;
        bus.sig_non_shift = a;
        bus.sig_shift     = b;
        bus.shift_amt     = amt;
        bus.exp_in        = e;
        if (v && rst_n) begin
            r = use_exp ? ex : model(a, b, amt, e);
            sb_q.push_back(r);
            last_exp = r;
        end
    endtask

    function automatic res_t mk(input logic [23:0] s, input logic [7:0] e,
                                input logic c, input logic o, input logic z);
        res_t r;
        r.sig = s; r.exp = e; r.cout = c; r.ovf = o; r.zero = z;
        return r;
    endfunction

    // Scoreboard monitor: compare every valid result with the queue head.
    always @(posedge clk) begin
        res_t ex;
        #1;
        if (bus.out_valid === 1'b1) begin
            if (sb_q.size() == 0) begin
                check("unexpected_out_valid", 32'(bus.out_valid), 32'd0);
            end else begin
                ex = sb_q.pop_front();
                check("norm_sig", 32'(bus.norm_sig), 32'(ex.sig));
                check("norm_exp", 32'(bus.norm_exp), 32'(ex.exp));
                check("flags",    32'({bus.cout, bus.overflow, bus.zero}),
                                  32'({ex.cout, ex.ovf, ex.zero}));
            end
        end
    end

    task automatic check_all_zero(input string tag);
        check({tag, "_valid"}, 32'(bus.out_valid), 32'd0);
        check({tag, "_data"},  32'({bus.norm_sig, bus.norm_exp}), 32'd0);
        check({tag, "_flags"}, 32'({bus.cout, bus.overflow, bus.zero}), 32'd0);
    endtask

    task automatic check_hold(input string tag);
        @(posedge clk);
        #2;
        check({tag, "_valid"}, 32'(bus.out_valid), 32'd0);
        check({tag, "_sig"},   32'(bus.norm_sig), 32'(last_exp.sig));
        check({tag, "_exp"},   32'(bus.norm_exp), 32'(last_exp.exp));
        check({tag, "_flags"}, 32'({bus.cout, bus.overflow, bus.zero}),
                               32'({last_exp.cout, last_exp.ovf, last_exp.zero}));
    endtask

    initial begin
        res_t none;
        none  = '0;
        n_vec = 0;
        n_err = 0;
        rst_n = 1'b0;
        bus.in_valid = 1'b0; bus.sig_non_shift = '0; bus.sig_shift = '0;
        bus.shift_amt = '0;  bus.exp_in = '0;
        repeat (2) @(negedge clk);
        check_all_zero("reset");

        @(negedge clk);
        rst_n = 1'b1;

        // Directed vectors with hand-derived expectations, back-to-back.
        apply(1'b1, 24'h800000, 24'h800000, 8'd0,  8'h7F, 1'b1, mk(24'h800000, 8'h80, 1'b1, 1'b0, 1'b0));
        apply(1'b1, 24'hC00000, 24'h800000, 8'd1,  8'h7F, 1'b1, mk(24'h800000, 8'h80, 1'b1, 1'b0, 1'b0));
        apply(1'b1, 24'hA00000, 24'hFFFFFF, 8'd30, 8'h33, 1'b1, mk(24'hA00000, 8'h33, 1'b0, 1'b0, 1'b0));
        apply(1'b1, 24'h800000, 24'h800000, 8'd0,  8'hFE, 1'b1, mk(24'h800000, 8'hFF, 1'b1, 1'b1, 1'b0));
        apply(1'b1, 24'h800000, 24'h800000, 8'd0,  8'hFF, 1'b1, mk(24'h800000, 8'hFF, 1'b1, 1'b1, 1'b0));
        apply(1'b1, 24'h000010, 24'h123456, 8'd24, 8'h40, 1'b1, mk(24'h800000, 8'h2D, 1'b0, 1'b0, 1'b0));
        apply(1'b1, 24'h000010, 24'h123456, 8'd24, 8'h10, 1'b1, mk(24'h080000, 8'h00, 1'b0, 1'b0, 1'b0));
        apply(1'b1, 24'h000000, 24'h000000, 8'd0,  8'h10, 1'b1, mk(24'h000000, 8'h00, 1'b0, 1'b0, 1'b1));
        apply(1'b1, 24'h400000, 24'h000000, 8'd0,  8'h00, 1'b1, mk(24'h400000, 8'h00, 1'b0, 1'b0, 1'b0));
        apply(1'b1, 24'h000FFF, 24'h000001, 8'd0,  8'h14, 1'b1, mk(24'h800000, 8'h09, 1'b0, 1'b0, 1'b0));
        apply(1'b1, 24'hFFFFFF, 24'hFFFFFF, 8'd23, 8'h20, 1'b1, mk(24'h800000, 8'h21, 1'b1, 1'b0, 1'b0));
        // out_valid must stay high across the back-to-back run.
        @(posedge clk); #2;
        check("b2b_valid", 32'(bus.out_valid), 32'd1);

        // Idle: out_valid drops, data holds even with new garbage on the bus.
        apply(1'b0, 24'h5A5A5A, 24'hA5A5A5, 8'd3, 8'h77, 1'b0, none);
        check_hold("idle");

        // Random vectors checked against the model.
        for (int i = 0; i < 300; i++) begin
            logic [23:0] a, b;
            logic [7:0]  amt, e;
            a   = 24'($urandom);
            b   = 24'($urandom);
            if ($urandom_range(0, 3) != 0) begin
                a[23] = 1'b1;
                b[23] = 1'b1;
            end
            amt = (i % 5 == 0) ? 8'($urandom) : 8'($urandom_range(0, 26));
            e   = (i % 7 == 0) ? 8'($urandom_range(0, 4)) :
                  (i % 7 == 1) ? 8'($urandom_range(250, 255)) : 8'($urandom);
            apply(($urandom_range(0, 4) != 0) ? 1'b1 : 1'b0, a, b, amt, e, 1'b0, none);
        end

        // Reset wins over in_valid.
        apply(1'b1, 24'h800000, 24'h800000, 8'd0, 8'h7F, 1'b0, none);
        @(negedge clk);
        rst_n = 1'b0;
        bus.in_valid = 1'b1;
        @(posedge clk); #2;
        check_all_zero("reset_mid");
        @(negedge clk);
        rst_n = 1'b1;
        bus.in_valid = 1'b0;
        repeat (2) @(negedge clk);

        check("sb_empty", 32'(sb_q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
